// File: rtl/image_frame_feeder.sv
// -----------------------------------------------------------------------------
// image_frame_feeder
//
// Collects one square image (IMG_SIZE x IMG_SIZE pixels, raster order) from a
// valid/ready byte stream into an internal frame buffer. Once the frame is
// complete, the feeder raises cnn_start and replays the whole buffer to the CNN
// line buffer as one gap-free burst. It then waits for cnn_done, pulses
// frame_done and counts the completed frame. A new frame can be accepted only
// after the feeder has returned to IDLE.
//
// Ports
//   clk          in   single clock, rising edge
//   rst          in   synchronous active-high reset, highest priority
//   s_data       in   incoming pixel (PIXEL_WIDTH bits)
//   s_valid      in   s_data is valid
//   s_ready      out  feeder accepts s_data (IDLE and LOAD only)
//   abort        in   drop the current frame and return to IDLE
//   cnn_start    out  enable level to the CNN, high in STREAM and WAIT_DONE
//   pixel_out    out  pixel streamed to the CNN (PIXEL_WIDTH bits)
//   pixel_valid  out  pixel_out is valid this cycle
//   cnn_done     in   CNN classification complete (used only in WAIT_DONE)
//   frame_done   out  one-cycle pulse when a frame has been classified
//   busy         out  high in every state except IDLE
//   frame_count  out  completed frames, wraps (CNT_WIDTH bits)
// -----------------------------------------------------------------------------
module image_frame_feeder #(
    parameter int IMG_SIZE    = 28,
    parameter int PIXEL_WIDTH = 8,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PIXEL_WIDTH-1:0] s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic                   abort,
    output logic                   cnn_start,
    output logic [PIXEL_WIDTH-1:0] pixel_out,
    output logic                   pixel_valid,
    input  logic                   cnn_done,
    output logic                   frame_done,
    output logic                   busy,
    output logic [CNT_WIDTH-1:0]   frame_count
);

    localparam int NUM_PIXELS = IMG_SIZE * IMG_SIZE;
    // Counters must be able to hold NUM_PIXELS itself (end-of-stream marker).
    localparam int IDX_W  = $clog2(NUM_PIXELS + 1);
    localparam int ADDR_W = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_PIXELS - 1);
    localparam logic [IDX_W-1:0] PIX_TOTAL = IDX_W'(NUM_PIXELS);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        STREAM    = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       load_cnt_q, load_cnt_d;
    logic [IDX_W-1:0]       rd_cnt_q, rd_cnt_d;
    logic                   s_ready_q, s_ready_d;
    logic                   busy_q, busy_d;
    logic                   cnn_start_q, cnn_start_d;
    logic                   pixel_valid_q, pixel_valid_d;
    logic                   frame_done_q, frame_done_d;
    logic [CNT_WIDTH-1:0]   frame_count_q, frame_count_d;
    logic [PIXEL_WIDTH-1:0] pixel_q;

    logic                   wr_en;
    logic                   rd_en;
    logic [ADDR_W-1:0]      wr_addr;
    logic [ADDR_W-1:0]      rd_addr;

    // Frame storage: deliberately not reset, every frame is fully rewritten
    // before it is streamed.
    logic [PIXEL_WIDTH-1:0] frame_mem [NUM_PIXELS];

    assign wr_addr = load_cnt_q[ADDR_W-1:0];
    assign rd_addr = rd_cnt_q[ADDR_W-1:0];

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        load_cnt_d    = load_cnt_q;
        rd_cnt_d      = rd_cnt_q;
        frame_done_d  = 1'b0;
        frame_count_d = frame_count_q;
        wr_en         = 1'b0;
        rd_en         = 1'b0;

        if (abort) begin
            // Abort beats everything, including a transfer or cnn_done in
            // the same cycle.
            state_d    = IDLE;
            load_cnt_d = '0;
            rd_cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE, LOAD: begin
                    // s_ready_q is high in both states, so s_valid alone
                    // marks a transfer here.
                    if (s_valid) begin
                        wr_en = 1'b1;
                        if (load_cnt_q == LAST_IDX) begin
                            state_d    = STREAM;
                            load_cnt_d = '0;
                        end else begin
                            state_d    = LOAD;
                            load_cnt_d = load_cnt_q + 1'b1;
                        end
                    end
                end
                STREAM: begin
                    // One read per cycle for NUM_PIXELS cycles starting on the
                    // entry cycle; the extra cycle drains the read latency.
                    if (rd_cnt_q == PIX_TOTAL) begin
                        state_d  = WAIT_DONE;
                        rd_cnt_d = '0;
                    end else begin
                        rd_en    = 1'b1;
                        rd_cnt_d = rd_cnt_q + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (cnn_done) begin
                        state_d       = IDLE;
                        frame_done_d  = 1'b1;
                        frame_count_d = frame_count_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Outputs are registered from the next state so they line up with
        // the state they describe.
        s_ready_d     = (state_d == IDLE) || (state_d == LOAD);
        busy_d        = (state_d != IDLE);
        cnn_start_d   = (state_d == STREAM) || (state_d == WAIT_DONE);
        pixel_valid_d = rd_en;
    end

    // -------------------------------------------------------------------------
    // FSM and control registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            load_cnt_q    <= '0;
            rd_cnt_q      <= '0;
            s_ready_q     <= 1'b1;
            busy_q        <= 1'b0;
            cnn_start_q   <= 1'b0;
            pixel_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            load_cnt_q    <= load_cnt_d;
            rd_cnt_q      <= rd_cnt_d;
            s_ready_q     <= s_ready_d;
            busy_q        <= busy_d;
            cnn_start_q   <= cnn_start_d;
            pixel_valid_q <= pixel_valid_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
        end
    end

    // -------------------------------------------------------------------------
    // Frame buffer write port
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            frame_mem[wr_addr] <= s_data;
        end
    end

    // -------------------------------------------------------------------------
    // Frame buffer read port (one-cycle latency); holds its value between reads
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_q <= '0;
        end else if (rd_en) begin
            pixel_q <= frame_mem[rd_addr];
        end
    end

    assign s_ready     = s_ready_q;
    assign busy        = busy_q;
    assign cnn_start   = cnn_start_q;
    assign pixel_valid = pixel_valid_q;
    assign pixel_out   = pixel_q;
    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_image_frame_feeder.sv
// -----------------------------------------------------------------------------
// Testbench for image_frame_feeder (28x28 frame, 8-bit pixels, 2-bit frame
// counter so the wrap-around is reached after four frames).
// Inputs are driven 1 ns after each rising edge; outputs are sampled at the
// same point, where they reflect the state entered on that edge.
// -----------------------------------------------------------------------------
module tb_image_frame_feeder;

    localparam int IMG_SIZE = 28;
    localparam int PW       = 8;
    localparam int CW       = 2;
    localparam int NP       = IMG_SIZE * IMG_SIZE;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [PW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic          abort = 1'b0;
    logic          cnn_start;
    logic [PW-1:0] pixel_out;
    logic          pixel_valid;
    logic          cnn_done = 1'b0;
    logic          frame_done;
    logic          busy;
    logic [CW-1:0] frame_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] frame_data [NP];
    logic [7:0] cap_data   [NP];
    logic       cap_vld    [NP];
    logic       ent_ready, ent_start, ent_vld, ent_busy;
    logic       post_vld, post_start, post_busy;

    always #5 clk = ~clk;

    image_frame_feeder #(
        .IMG_SIZE   (IMG_SIZE),
        .PIXEL_WIDTH(PW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .abort      (abort),
        .cnn_start  (cnn_start),
        .pixel_out  (pixel_out),
        .pixel_valid(pixel_valid),
        .cnn_done   (cnn_done),
        .frame_done (frame_done),
        .busy       (busy),
        .frame_count(frame_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pushes frame_data into the DUT, optionally with random idle cycles.
    // A byte counts as accepted only when s_ready was high as it was offered.
    task automatic drive_frame(input bit gaps, output int accepted, output int cycles);
        accepted = 0;
        cycles   = 0;
        while (accepted < NP && cycles < 8 * NP) begin
            if (gaps && $urandom_range(0, 1) == 0) begin
                s_valid = 1'b0;
                s_data  = 8'hEE;
                step();
            end else begin
                s_valid = 1'b1;
                s_data  = frame_data[accepted];
                if (s_ready) begin
                    step();
                    accepted++;
                end else begin
                    step();
                end
            end
            cycles++;
        end
        s_valid = 1'b0;
        s_data  = '0;
    endtask

    // Called on the STREAM entry cycle; records the entry cycle, the next NP
    // cycles and the cycle after them (WAIT_DONE).
    task automatic capture_stream();
        ent_ready = s_ready;
        ent_start = cnn_start;
        ent_vld   = pixel_valid;
        ent_busy  = busy;
        step();
        for (int i = 0; i < NP; i++) begin
            cap_vld[i]  = pixel_valid;
            cap_data[i] = pixel_out;
            step();
        end
        post_vld   = pixel_valid;
        post_start = cnn_start;
        post_busy  = busy;
    endtask

    task automatic test_reset();
        rst = 1'b1; s_valid = 1'b1; abort = 1'b1; cnn_done = 1'b1; s_data = 8'hAA;
        repeat (3) step();
        n_checks++; if (cnn_start !== 1'b0) begin n_fail++; $display("FAIL rst_cnn_start: got %b want 0", cnn_start); end
        n_checks++; if (pixel_valid !== 1'b0) begin n_fail++; $display("FAIL rst_pixel_valid: got %b want 0", pixel_valid); end
        n_checks++; if (pixel_out !== 8'h00) begin n_fail++; $display("FAIL rst_pixel_out: got %h want 00", pixel_out); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_frame_done: got %b want 0", frame_done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_checks++; if (frame_count !== 2'd0) begin n_fail++; $display("FAIL rst_frame_count: got %0d want 0", frame_count); end
        rst = 1'b0; s_valid = 1'b0; abort = 1'b0; cnn_done = 1'b0; s_data = '0;
        step();
        n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL rst_s_ready: got %b want 1", s_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_full_frame();
        int acc, cyc;
        bit early_done;
        for (int i = 0; i < NP; i++) frame_data[i] = 8'(i);
        drive_frame(1'b0, acc, cyc);
        n_checks++; if (acc !== NP) begin n_fail++; $display("FAIL full_accepted: got %0d want %0d", acc, NP); end
        capture_stream();
        n_checks++; if (ent_ready !== 1'b0) begin n_fail++; $display("FAIL full_entry_s_ready: got %b want 0", ent_ready); end
        n_checks++; if (ent_start !== 1'b1) begin n_fail++; $display("FAIL full_entry_cnn_start: got %b want 1", ent_start); end
        n_checks++; if (ent_vld !== 1'b0) begin n_fail++; $display("FAIL full_entry_pixel_valid: got %b want 0", ent_vld); end
        n_checks++; if (ent_busy !== 1'b1) begin n_fail++; $display("FAIL full_entry_busy: got %b want 1", ent_busy); end
        for (int i = 0; i < NP; i++) begin
            n_checks++;
            if (cap_vld[i] !== 1'b1 || cap_data[i] !== frame_data[i]) begin
                n_fail++;
                $display("FAIL full_pixel[%0d]: got vld=%b data=%h want vld=1 data=%h", i, cap_vld[i], cap_data[i], frame_data[i]);
            end
        end
        n_checks++; if (cap_data[256] !== 8'h00) begin n_fail++; $display("FAIL full_pixel256: got %h want 00", cap_data[256]); end
        n_checks++; if (cap_data[NP-1] !== 8'h0F) begin n_fail++; $display("FAIL full_pixel_last: got %h want 0f", cap_data[NP-1]); end
        n_checks++; if (post_vld !== 1'b0) begin n_fail++; $display("FAIL full_wait_pixel_valid: got %b want 0", post_vld); end
        n_checks++; if (post_start !== 1'b1) begin n_fail++; $display("FAIL full_wait_cnn_start: got %b want 1", post_start); end
        n_checks++; if (post_busy !== 1'b1) begin n_fail++; $display("FAIL full_wait_busy: got %b want 1", post_busy); end
        early_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (frame_done !== 1'b0 || cnn_start !== 1'b1) early_done = 1'b1;
            step();
        end
        n_checks++; if (early_done !== 1'b0) begin n_fail++; $display("FAIL full_wait_hold: got %b want 0", early_done); end
        cnn_done = 1'b1;
        step();
        cnn_done = 1'b0;
        n_checks++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL full_frame_done: got %b want 1", frame_done); end
        n_checks++; if (cnn_start !== 1'b0) begin n_fail++; $display("FAIL full_done_cnn_start: got %b want 0", cnn_start); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL full_done_busy: got %b want 0", busy); end
        n_checks++; if (frame_count !== 2'd1) begin n_fail++; $display("FAIL full_frame_count: got %0d want 1", frame_count); end
        n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL full_done_s_ready: got %b want 1", s_ready); end
        step();
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL full_frame_done_pulse: got %b want 0", frame_done); end
    endtask

    task automatic test_gapped_load();
        int acc, cyc;
        for (int i = 0; i < NP; i++) frame_data[i] = 8'(i * 7 + 3);
        drive_frame(1'b1, acc, cyc);
        n_checks++; if (acc !== NP) begin n_fail++; $display("FAIL gap_accepted: got %0d want %0d", acc, NP); end
        capture_stream();
        n_checks++; if (ent_start !== 1'b1 || ent_vld !== 1'b0) begin n_fail++; $display("FAIL gap_entry: got start=%b vld=%b want start=1 vld=0", ent_start, ent_vld); end
        for (int i = 0; i < NP; i++) begin
            n_checks++;
            if (cap_vld[i] !== 1'b1 || cap_data[i] !== frame_data[i]) begin
                n_fail++;
                $display("FAIL gap_pixel[%0d]: got vld=%b data=%h want vld=1 data=%h", i, cap_vld[i], cap_data[i], frame_data[i]);
            end
        end
        n_checks++; if (cap_data[1] !== 8'h0A) begin n_fail++; $display("FAIL gap_pixel1: got %h want 0a", cap_data[1]); end
        n_checks++; if (post_vld !== 1'b0) begin n_fail++; $display("FAIL gap_wait_pixel_valid: got %b want 0", post_vld); end
        cnn_done = 1'b1;
        step();
        cnn_done = 1'b0;
        n_checks++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL gap_frame_done: got %b want 1", frame_done); end
        n_checks++; if (frame_count !== 2'd2) begin n_fail++; $display("FAIL gap_frame_count: got %0d want 2", frame_count); end
        step();
    endtask

    task automatic test_abort_stream();
        int acc, cyc;
        for (int i = 0; i < NP; i++) frame_data[i] = 8'(255 - i);
        drive_frame(1'b0, acc, cyc);
        n_checks++; if (cnn_start !== 1'b1) begin n_fail++; $display("FAIL abort_entry_cnn_start: got %b want 1", cnn_start); end
        repeat (400) step();
        n_checks++; if (pixel_valid !== 1'b1 || pixel_out !== 8'h70) begin n_fail++; $display("FAIL abort_pixel400: got vld=%b data=%h want vld=1 data=70", pixel_valid, pixel_out); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_checks++; if (pixel_valid !== 1'b0) begin n_fail++; $display("FAIL abort_pixel_valid: got %b want 0", pixel_valid); end
        n_checks++; if (cnn_start !== 1'b0) begin n_fail++; $display("FAIL abort_cnn_start: got %b want 0", cnn_start); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL abort_s_ready: got %b want 1", s_ready); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL abort_frame_done: got %b want 0", frame_done); end
        n_checks++; if (frame_count !== 2'd2) begin n_fail++; $display("FAIL abort_frame_count: got %0d want 2", frame_count); end
        // A transfer offered together with abort must be dropped.
        s_valid = 1'b1; s_data = 8'h33; abort = 1'b1;
        step();
        s_valid = 1'b0; abort = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_drop_xfer_busy: got %b want 0", busy); end
        for (int i = 0; i < NP; i++) frame_data[i] = 8'(i) ^ 8'h5A;
        drive_frame(1'b0, acc, cyc);
        n_checks++; if (acc !== NP) begin n_fail++; $display("FAIL abort_fresh_accepted: got %0d want %0d", acc, NP); end
        capture_stream();
        for (int i = 0; i < NP; i++) begin
            n_checks++;
            if (cap_vld[i] !== 1'b1 || cap_data[i] !== frame_data[i]) begin
                n_fail++;
                $display("FAIL abort_fresh_pixel[%0d]: got vld=%b data=%h want vld=1 data=%h", i, cap_vld[i], cap_data[i], frame_data[i]);
            end
        end
        n_checks++; if (cap_data[0] !== 8'h5A || cap_data[NP-1] !== 8'h55) begin n_fail++; $display("FAIL abort_fresh_ends: got %h/%h want 5a/55", cap_data[0], cap_data[NP-1]); end
        cnn_done = 1'b1;
        step();
        cnn_done = 1'b0;
        n_checks++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL abort_fresh_frame_done: got %b want 1", frame_done); end
        n_checks++; if (frame_count !== 2'd3) begin n_fail++; $display("FAIL abort_fresh_frame_count: got %0d want 3", frame_count); end
        step();
    endtask

    task automatic test_abort_vs_done();
        int acc, cyc;
        for (int i = 0; i < NP; i++) frame_data[i] = 8'(i + 100);
        // cnn_done held through the whole load must have no effect.
        cnn_done = 1'b1;
        drive_frame(1'b0, acc, cyc);
        cnn_done = 1'b0;
        n_checks++; if (acc !== NP || cyc !== NP) begin n_fail++; $display("FAIL avd_load: got acc=%0d cyc=%0d want %0d/%0d", acc, cyc, NP, NP); end
        capture_stream();
        n_checks++; if (ent_start !== 1'b1) begin n_fail++; $display("FAIL avd_entry_cnn_start: got %b want 1", ent_start); end
        for (int i = 0; i < NP; i++) begin
            n_checks++;
            if (cap_vld[i] !== 1'b1 || cap_data[i] !== frame_data[i]) begin
                n_fail++;
                $display("FAIL avd_pixel[%0d]: got vld=%b data=%h want vld=1 data=%h", i, cap_vld[i], cap_data[i], frame_data[i]);
            end
        end
        n_checks++; if (post_busy !== 1'b1 || frame_done !== 1'b0) begin n_fail++; $display("FAIL avd_wait: got busy=%b done=%b want busy=1 done=0", post_busy, frame_done); end
        abort = 1'b1; cnn_done = 1'b1;
        step();
        abort = 1'b0; cnn_done = 1'b0;
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL avd_frame_done: got %b want 0", frame_done); end
        n_checks++; if (frame_count !== 2'd3) begin n_fail++; $display("FAIL avd_frame_count: got %0d want 3", frame_count); end
        n_checks++; if (busy !== 1'b0 || cnn_start !== 1'b0) begin n_fail++; $display("FAIL avd_idle: got busy=%b start=%b want 0/0", busy, cnn_start); end
        step();
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL avd_frame_done_late: got %b want 0", frame_done); end
    endtask

    task automatic test_wrap_back_to_back();
        int acc, cyc;
        for (int i = 0; i < NP; i++) frame_data[i] = 8'(i * 13);
        drive_frame(1'b0, acc, cyc);
        capture_stream();
        for (int i = 0; i < NP; i++) begin
            n_checks++;
            if (cap_vld[i] !== 1'b1 || cap_data[i] !== frame_data[i]) begin
                n_fail++;
                $display("FAIL wrap_pixel[%0d]: got vld=%b data=%h want vld=1 data=%h", i, cap_vld[i], cap_data[i], frame_data[i]);
            end
        end
        cnn_done = 1'b1;
        step();
        cnn_done = 1'b0;
        n_checks++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL wrap_frame_done: got %b want 1", frame_done); end
        n_checks++; if (frame_count !== 2'd0) begin n_fail++; $display("FAIL wrap_frame_count: got %0d want 0", frame_count); end
        // Next frame starts on the very first IDLE cycle with no stall.
        for (int i = 0; i < NP; i++) frame_data[i] = 8'(i) ^ 8'hFF;
        drive_frame(1'b0, acc, cyc);
        n_checks++; if (acc !== NP || cyc !== NP) begin n_fail++; $display("FAIL b2b_load: got acc=%0d cyc=%0d want %0d/%0d", acc, cyc, NP, NP); end
        capture_stream();
        for (int i = 0; i < NP; i++) begin
            n_checks++;
            if (cap_vld[i] !== 1'b1 || cap_data[i] !== frame_data[i]) begin
                n_fail++;
                $display("FAIL b2b_pixel[%0d]: got vld=%b data=%h want vld=1 data=%h", i, cap_vld[i], cap_data[i], frame_data[i]);
            end
        end
        n_checks++; if (cap_data[NP-1] !== 8'hF0) begin n_fail++; $display("FAIL b2b_pixel_last: got %h want f0", cap_data[NP-1]); end
        cnn_done = 1'b1;
        step();
        cnn_done = 1'b0;
        n_checks++; if (frame_count !== 2'd1) begin n_fail++; $display("FAIL b2b_frame_count: got %0d want 1", frame_count); end
        step();
    endtask

    task automatic test_reset_mid_load();
        int acc, cyc;
        for (int i = 0; i < 300; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(i + 1);
            step();
        end
        n_checks++; if (busy !== 1'b1 || s_ready !== 1'b1) begin n_fail++; $display("FAIL rml_loading: got busy=%b ready=%b want 1/1", busy, s_ready); end
        rst = 1'b1;
        step();
        rst = 1'b0; s_valid = 1'b0; s_data = '0;
        n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL rml_s_ready: got %b want 1", s_ready); end
        n_checks++; if (cnn_start !== 1'b0) begin n_fail++; $display("FAIL rml_cnn_start: got %b want 0", cnn_start); end
        n_checks++; if (pixel_valid !== 1'b0) begin n_fail++; $display("FAIL rml_pixel_valid: got %b want 0", pixel_valid); end
        n_checks++; if (pixel_out !== 8'h00) begin n_fail++; $display("FAIL rml_pixel_out: got %h want 00", pixel_out); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rml_frame_done: got %b want 0", frame_done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rml_busy: got %b want 0", busy); end
        n_checks++; if (frame_count !== 2'd0) begin n_fail++; $display("FAIL rml_frame_count: got %0d want 0", frame_count); end
        // Load counter must restart at 0 after the reset.
        for (int i = 0; i < NP; i++) frame_data[i] = 8'(i * 5 + 1);
        drive_frame(1'b0, acc, cyc);
        n_checks++; if (acc !== NP || cyc !== NP) begin n_fail++; $display("FAIL rml_reload: got acc=%0d cyc=%0d want %0d/%0d", acc, cyc, NP, NP); end
        capture_stream();
        for (int i = 0; i < NP; i++) begin
            n_checks++;
            if (cap_vld[i] !== 1'b1 || cap_data[i] !== frame_data[i]) begin
                n_fail++;
                $display("FAIL rml_pixel[%0d]: got vld=%b data=%h want vld=1 data=%h", i, cap_vld[i], cap_data[i], frame_data[i]);
            end
        end
        n_checks++; if (cap_data[0] !== 8'h01) begin n_fail++; $display("FAIL rml_pixel0: got %h want 01", cap_data[0]); end
        cnn_done = 1'b1;
        step();
        cnn_done = 1'b0;
        n_checks++; if (frame_done !== 1'b1 || frame_count !== 2'd1) begin n_fail++; $display("FAIL rml_done: got done=%b count=%0d want 1/1", frame_done, frame_count); end
        step();
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_gapped_load();
        test_abort_stream();
        test_abort_vs_done();
        test_wrap_back_to_back();
        test_reset_mid_load();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/image_frame_feeder.md
IMAGE_FRAME_FEEDER -- requirements
Module: image_frame_feeder

Interface
REQ-001: Parameter IMG_SIZE, default 28, image side length in pixels; frame holds NUM_PIXELS = IMG_SIZE*IMG_SIZE pixels (784).
REQ-002: Parameter PIXEL_WIDTH, default 8, pixel bit width.
REQ-003: Parameter CNT_WIDTH, default 16, width of frame_count.
REQ-004: clk  input  1  single clock; all logic on rising edge.
REQ-005: rst  input  1  synchronous, active-high reset.
REQ-006: s_data  input  PIXEL_WIDTH  incoming pixel byte, raster order.
REQ-007: s_valid  input  1  s_data valid.
REQ-008: s_ready  output  1  feeder can accept s_data.
REQ-009: abort  input  1  discard current frame, return to IDLE.
REQ-010: cnn_start  output  1  enable/start level to CNN pipeline.
REQ-011: pixel_out  output  PIXEL_WIDTH  pixel streamed to CNN line buffer.
REQ-012: pixel_valid  output  1  pixel_out valid this cycle.
REQ-013: cnn_done  input  1  CNN classification complete.
REQ-014: frame_done  output  1  one-cycle pulse, frame fully classified.
REQ-015: busy  output  1  high in any state except IDLE.
REQ-016: frame_count  output  CNT_WIDTH  completed frames, wraps to 0 after all-ones.

Function
REQ-017: FSM states IDLE, LOAD, STREAM, WAIT_DONE; internal frame buffer NUM_PIXELS x PIXEL_WIDTH, synchronous read, one-cycle read latency.
REQ-018: Transfer occurs on cycle with s_valid && s_ready; s_ready = 1 in IDLE and LOAD only, 0 otherwise.
REQ-019: IDLE: first transfer writes buffer[0], load counter = 1, next state LOAD; no transfer keeps IDLE.
REQ-020: LOAD: each transfer writes buffer[counter], counter increments; transfer writing index NUM_PIXELS-1 moves to STREAM next cycle; s_valid gaps stall without effect.
REQ-021: STREAM entry cycle: cnn_start = 1, pixel_valid = 0, read address 0 issued.
REQ-022: STREAM: following NUM_PIXELS consecutive cycles pixel_valid = 1, pixel_out = buffer[0..NUM_PIXELS-1] in order, no bubbles; cycle after last pixel moves to WAIT_DONE.
REQ-023: Total STREAM duration = NUM_PIXELS+1 cycles (785 for default).
REQ-024: WAIT_DONE: cnn_start = 1, pixel_valid = 0; cnn_done = 1 moves to IDLE next cycle, frame_done = 1 for that one cycle, frame_count increments.
REQ-025: cnn_start = 1 exactly in STREAM and WAIT_DONE; drops to 0 on cycle IDLE is re-entered.
REQ-026: cnn_done ignored in IDLE, LOAD, STREAM.
REQ-027: abort = 1 in any state: next state IDLE, counters cleared, cnn_start/pixel_valid 0 next cycle, no frame_done, frame_count unchanged; transfer coinciding with abort is dropped.
REQ-028: abort and cnn_done same cycle in WAIT_DONE: abort wins, no frame_done, no count increment.
REQ-029: Next frame load begins only after returning to IDLE; back-to-back frames allowed (transfer accepted in first IDLE cycle).
REQ-030: pixel_out holds last read value when pixel_valid = 0; consumers use it only with pixel_valid.
REQ-031: Buffer contents not cleared by reset or abort; every frame fully overwritten before streaming.

Reset
REQ-032: rst = 1 at clock edge: state IDLE, s_ready = 1 after reset released, cnn_start = 0, pixel_valid = 0, pixel_out = 0, frame_done = 0, busy = 0, frame_count = 0, internal counters = 0.
REQ-033: rst has priority over abort and all inputs; reset mid-LOAD/STREAM/WAIT_DONE discards frame with no frame_done.

Verification
REQ-034: Load 784 bytes value (i mod 256) with s_valid held -> s_ready drops after 784th transfer; cnn_start rises next cycle; pixel_valid high 784 cycles starting one cycle later, pixel_out = 0,1,...,255,0,...,15.
REQ-035: cnn_done pulse 20 cycles into WAIT_DONE -> next cycle frame_done = 1 one cycle, cnn_start = 0, frame_count = 1, busy = 0.
REQ-036: Load with random s_valid gaps (50% duty) -> streamed sequence identical to transferred sequence, stream contiguous 784 cycles.
REQ-037: abort at 400th pixel of STREAM -> pixel_valid and cnn_start 0 next cycle, state IDLE, frame_count unchanged; fresh frame then loads/streams correctly.
REQ-038: abort and cnn_done asserted same cycle in WAIT_DONE -> no frame_done, frame_count unchanged; separately, cnn_done during LOAD -> ignored.
REQ-039: rst asserted mid-LOAD after 300 bytes -> all outputs at reset values next cycle; frame_count preset near 0xFFFF via repeated frames (or CNT_WIDTH=2 build, 4 frames) -> wraps to 0.
